// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   A LIFO stack with a registered pop path, saturating entry count and
//   optional sticky error flags.
//
//   Optional feature macro: STACK_ERR_FLAGS_EN
//     defined   -> OVF/UNF latch illegal push-while-full / pop-while-empty
//                  and hold until RST
//     undefined -> OVF/UNF are tied low; illegal operations are still ignored
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   CLK    in   clock, all state on the rising edge
//   RST    in   synchronous active-high reset
//   PUSH   in   write DIN onto the top of the stack
//   POP    in   remove the top entry and return it on DOUT
//   DIN    in   push data
//   DOUT   out  popped data, registered, held while VALID is low
//   VALID  out  one-cycle pulse: DOUT carries data popped last cycle
//   SP     out  entry count, 0..DEPTH
//   EMPTY  out  SP == 0
//   FULL   out  SP == DEPTH
//   OVF    out  sticky overflow flag
//   UNF    out  sticky underflow flag
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [WIDTH-1:0]           DIN,
  output logic [WIDTH-1:0]           DOUT,
  output logic                       VALID,
  output logic [$clog2(DEPTH):0]     SP,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  logic             ovf_set;
  logic             unf_set;

  logic             empty;
  logic             full;
  logic [SPW-1:0]   sp_dec;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  // Flags decode straight from the registered count.
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SPW'(DEPTH));

  // sp_dec is only used when the stack is non-empty, so the low bits are
  // always a legal index. wr_idx is only used when not full, where SP < DEPTH.
  assign sp_dec  = sp_q - SPW'(1);
  assign top_idx = sp_dec[AW-1:0];
  assign wr_idx  = sp_q[AW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    unique case ({PUSH, POP})
      2'b10: begin
        if (!full) begin
          mem_we    = 1'b1;
          mem_waddr = wr_idx;
          sp_d      = sp_q + SPW'(1);
        end else begin
          ovf_set   = 1'b1;
        end
      end

      2'b01: begin
        if (!empty) begin
          dout_d    = mem_q[top_idx];
          valid_d   = 1'b1;
          sp_d      = sp_dec;
        end else begin
          unf_set   = 1'b1;
        end
      end

      2'b11: begin
        if (empty) begin
          // Nothing stored: the pushed word goes straight out.
          dout_d    = DIN;
          valid_d   = 1'b1;
        end else begin
          // Swap the top: old top goes out, DIN takes its place. Legal even
          // when full because the count does not change.
          dout_d    = mem_q[top_idx];
          valid_d   = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Storage is not reset; a write in a reset cycle is dropped so RST wins.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem_q[mem_waddr] <= DIN;
    end
  end

  // ---------------------------------------------------------------------------
  // Error flags
  // ---------------------------------------------------------------------------
`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;
`else
  logic unused_err_set;
  assign unused_err_set = ovf_set | unf_set;

  assign OVF = 1'b0;
  assign UNF = 1'b0;
`endif

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign SP    = sp_q;
  assign EMPTY = empty;
  assign FULL  = full;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

`ifdef STACK_ERR_FLAGS_EN
  localparam logic FLAG_EXP = 1'b1;
`else
  localparam logic FLAG_EXP = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] DOUT;
  logic             VALID;
  logic [2:0]       SP;
  logic             EMPTY;
  logic             FULL;
  logic             OVF;
  logic             UNF;

  int n_checks;
  int n_fail;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (PUSH),
    .POP   (POP),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .VALID (VALID),
    .SP    (SP),
    .EMPTY (EMPTY),
    .FULL  (FULL),
    .OVF   (OVF),
    .UNF   (UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic cycle(input logic rst, input logic push, input logic pop,
                       input logic [WIDTH-1:0] din);
    @(negedge CLK);
    RST  = rst;
    PUSH = push;
    POP  = pop;
    DIN  = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic [WIDTH-1:0] d,
                            input logic [2:0] sp);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check({tag, "_valid"}, 32'(VALID), 32'd1);
    check({tag, "_dout"},  32'(DOUT),  32'(d));
    check({tag, "_sp"},    32'(SP),    32'(sp));
  endtask

  initial begin
    logic [WIDTH-1:0] seq [4];
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b0; PUSH = 1'b0; POP = 1'b0; DIN = '0;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_sp",    32'(SP),    32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full",  32'(FULL),  32'd0);
    check("rst_dout",  32'(DOUT),  32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_ovf",   32'(OVF),   32'd0);
    check("rst_unf",   32'(UNF),   32'd0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, seq[i]);
      check("push_sp",    32'(SP),    32'(i + 1));
      check("push_valid", 32'(VALID), 32'd0);
    end
    check("fill_full",  32'(FULL),  32'd1);
    check("fill_empty", 32'(EMPTY), 32'd0);

    // Overflow: ignored
    cycle(1'b0, 1'b1, 1'b0, 8'h55);
    check("ovf_sp",    32'(SP),    32'd4);
    check("ovf_flag",  32'(OVF),   32'(FLAG_EXP));
    check("ovf_valid", 32'(VALID), 32'd0);

    // Drain, LIFO order; 0x55 must not appear
    pop_expect("pop0", 8'h44, 3'd3);
    pop_expect("pop1", 8'h33, 3'd2);
    pop_expect("pop2", 8'h22, 3'd1);
    pop_expect("pop3", 8'h11, 3'd0);
    check("drain_empty", 32'(EMPTY), 32'd1);

    // Underflow: ignored, DOUT held
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("unf_valid", 32'(VALID), 32'd0);
    check("unf_dout",  32'(DOUT),  32'h11);
    check("unf_sp",    32'(SP),    32'd0);
    check("unf_flag",  32'(UNF),   32'(FLAG_EXP));
    check("unf_ovf",   32'(OVF),   32'(FLAG_EXP));

    // Idle: VALID drops, DOUT holds, flags sticky
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_valid", 32'(VALID), 32'd0);
    check("idle_dout",  32'(DOUT),  32'h11);
    check("idle_unf",   32'(UNF),   32'(FLAG_EXP));

    // Simultaneous push+pop at SP=2
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst2_ovf", 32'(OVF), 32'd0);
    check("rst2_unf", 32'(UNF), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h11);
    cycle(1'b0, 1'b1, 1'b0, 8'h22);
    cycle(1'b0, 1'b1, 1'b1, 8'h99);
    check("swap_dout",  32'(DOUT),  32'h22);
    check("swap_valid", 32'(VALID), 32'd1);
    check("swap_sp",    32'(SP),    32'd2);
    pop_expect("swap_pop0", 8'h99, 3'd1);
    pop_expect("swap_pop1", 8'h11, 3'd0);

    // Pass-through when empty
    cycle(1'b0, 1'b1, 1'b1, 8'hA5);
    check("pass_dout",  32'(DOUT),  32'hA5);
    check("pass_valid", 32'(VALID), 32'd1);
    check("pass_sp",    32'(SP),    32'd0);
    check("pass_ovf",   32'(OVF),   32'd0);
    check("pass_unf",   32'(UNF),   32'd0);

    // Swap while full
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i + 1));
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    check("fswap_dout", 32'(DOUT), 32'h04);
    check("fswap_sp",   32'(SP),   32'd4);
    check("fswap_ovf",  32'(OVF),  32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'hEE);
    check("fswap_ovf2", 32'(OVF),  32'(FLAG_EXP));
    pop_expect("fswap_pop", 8'h77, 3'd3);

    // Reset beats a pop in the same cycle at SP=3
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    check("rpop_sp",    32'(SP),    32'd0);
    check("rpop_valid", 32'(VALID), 32'd0);
    check("rpop_dout",  32'(DOUT),  32'd0);
    check("rpop_ovf",   32'(OVF),   32'd0);
    check("rpop_unf",   32'(UNF),   32'd0);
    check("rpop_empty", 32'(EMPTY), 32'd1);

    // Reset also beats a push
    cycle(1'b1, 1'b1, 1'b0, 8'h3C);
    check("rpush_sp", 32'(SP), 32'd0);

    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of stack entries; a power of two, at least 2.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 PUSH  input  1  request to write DIN onto the top of the stack this cycle.
REQ-006 POP  input  1  request to remove the top entry and return it on DOUT.
REQ-007 DIN  input  WIDTH  push data.
REQ-008 DOUT  output  WIDTH  popped data, registered.
REQ-009 VALID  output  1  DOUT holds data popped in the previous cycle; one-cycle pulse.
REQ-010 SP  output  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-011 EMPTY  output  1  high when SP==0.
REQ-012 FULL  output  1  high when SP==DEPTH.
REQ-013 OVF  output  1  sticky overflow flag.
REQ-014 UNF  output  1  sticky underflow flag.

Function
REQ-015 Storage SHALL be an internal array of DEPTH words; the top entry is at index SP-1.
REQ-016 PUSH only, not FULL: write DIN at index SP, then SP+1 next cycle; VALID stays 0.
REQ-017 POP only, not EMPTY: DOUT <= mem[SP-1] and VALID=1 in the next cycle; SP-1.
REQ-018 Pop latency SHALL be exactly one cycle from the POP edge to VALID/DOUT.
REQ-019 PUSH and POP together, not EMPTY: DOUT <= old top, VALID=1, top overwritten with DIN, SP unchanged; this also applies when FULL.
REQ-020 PUSH and POP together, EMPTY: pass-through; DOUT <= DIN, VALID=1, SP stays 0, no flag set.
REQ-021 PUSH only while FULL: ignored; SP and memory unchanged; OVF set when enabled (REQ-029).
REQ-022 POP only while EMPTY: ignored; VALID=0 and DOUT holds its last value; UNF set when enabled.
REQ-023 DOUT SHALL hold its last value whenever VALID is 0.
REQ-024 SP SHALL never wrap: never below 0, never above DEPTH.
REQ-025 EMPTY and FULL SHALL be decoded combinationally from the registered SP.

Reset
REQ-026 On RST high at a rising edge: SP=0, EMPTY=1, FULL=0, DOUT=0, VALID=0, OVF=0, UNF=0.
REQ-027 RST SHALL take priority over PUSH and POP in the same cycle; an in-flight pop result is discarded.
REQ-028 Memory contents SHALL NOT be reset; they are unreadable until written again.

Configuration
REQ-029 With macro STACK_ERR_FLAGS_EN defined: OVF and UNF set on the illegal operations in REQ-021/REQ-022 and stay set until RST.
REQ-030 Without STACK_ERR_FLAGS_EN: OVF and UNF tied to 0; illegal operations are still ignored exactly as in REQ-021/REQ-022.

Verification (DEPTH=4, WIDTH=8, STACK_ERR_FLAGS_EN defined)
REQ-031 RST, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> SP=4, FULL=1, EMPTY=0.
REQ-032 From REQ-031, four POP cycles -> VALID pulses with DOUT 0x44,0x33,0x22,0x11, each one cycle later; SP=0, EMPTY=1.
REQ-033 Full stack, PUSH 0x55 -> SP stays 4, OVF=1, contents unchanged on pop-out; empty stack, POP -> VALID=0, UNF=1.
REQ-034 SP=2 with top 0x22, PUSH+POP with DIN=0x99 -> DOUT=0x22, VALID=1, SP=2; next POP -> DOUT=0x99.
REQ-035 Empty stack, PUSH+POP with DIN=0xA5 -> next cycle DOUT=0xA5, VALID=1, SP=0; no flags set.
REQ-036 SP=3 with a POP and RST asserted in the same cycle -> SP=0, VALID=0, DOUT=0, flags cleared; rebuild without the macro -> REQ-033 stimulus leaves OVF=UNF=0.
